// File: rtl/digit_editor_pkg.sv
// Shared constants, action encoding and helpers for the front-panel digit editor.
package digit_editor_pkg;

  localparam logic [5:0] DISP_MASK  = 6'b11_0001;
  localparam int         MAX_DIGITS = 99;
  localparam int         MAX_RADIX  = 16;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_CLR,
    ACT_INC,
    ACT_DEC,
    ACT_NXT,
    ACT_PRV
  } action_e;

  function automatic int cursor_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_editor_blink.sv
// Blink phase generator: toggles phase every DIV cycles; restart forces phase on.
module blink_timer #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic phase
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n || restart) begin
      count <= '0;
      phase <= 1'b1;
    end else if (count == CW'(DIV - 1)) begin
      count <= '0;
      phase <= ~phase;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/digit_editor.sv
// Multi-digit front-panel editor with cursor and seven-segment bundle.
// Optional blinking of the edited digit: define DIGIT_EDITOR_BLINK_EN.
module digit_editor
  import digit_editor_pkg::*;
#(
  parameter int DIGITS    = 10,
  parameter int RADIX     = 10,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              inc,
  input  logic                              dec,
  input  logic                              nxt,
  input  logic                              prv,
  input  logic                              clr,
  output logic [4*DIGITS-1:0]               mem,
  output logic [cursor_width(DIGITS)-1:0]   addr,
  output logic [3:0]                        cur,
  output logic                              changed,
  output logic [5:0]                        e,
  output logic [23:0]                       d
);

  localparam int AW = cursor_width(DIGITS);

  action_e    act;
  logic [3:0] digit [DIGITS];
  logic [4:0] sum5;
  logic [4:0] diff5;
  logic [3:0] inc_val;
  logic [3:0] dec_val;
  logic [6:0] pos;

  always_comb begin
    act = ACT_NONE;
    if      (clr) act = ACT_CLR;
    else if (inc) act = ACT_INC;
    else if (dec) act = ACT_DEC;
    else if (nxt) act = ACT_NXT;
    else if (prv) act = ACT_PRV;
  end

  assign cur = digit[addr];

  // 5-bit arithmetic so the RADIX=16 wrap is visible before truncation
  always_comb begin
    sum5    = {1'b0, cur} + 5'd1;
    diff5   = {1'b0, cur} - 5'd1;
    inc_val = (sum5 == 5'(RADIX)) ? '0 : sum5[3:0];
    dec_val = (cur == '0) ? 4'(RADIX - 1) : diff5[3:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digit   <= '{default: '0};
      addr    <= '0;
      changed <= 1'b0;
    end else begin
      changed <= (act == ACT_CLR) || (act == ACT_INC) || (act == ACT_DEC);
      case (act)
        ACT_CLR: digit      <= '{default: '0};
        ACT_INC: digit[addr] <= inc_val;
        ACT_DEC: digit[addr] <= dec_val;
        ACT_NXT: addr <= (addr == AW'(DIGITS - 1)) ? '0 : addr + 1'b1;
        ACT_PRV: addr <= (addr == '0) ? AW'(DIGITS - 1) : addr - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem = '0;
    for (int unsigned i = 0; i < DIGITS; i++) mem[4*i +: 4] = digit[i];
  end

  always_comb begin
    pos      = 7'(addr) + 7'd1;
    d        = '0;
    d[23:20] = 4'(pos / 7'd10);
    d[19:16] = 4'(pos % 7'd10);
    d[3:0]   = cur;
  end

`ifdef DIGIT_EDITOR_BLINK_EN
  logic phase;

  blink_timer #(.DIV(BLINK_DIV)) u_blink (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (act != ACT_NONE),
    .phase   (phase)
  );

  assign e = {DISP_MASK[5:1], phase};
`else
  assign e = DISP_MASK;
`endif

endmodule

// File: tb/tb_digit_editor.sv
// Randomised self-checking bench for digit_editor against a behavioural model.
module tb_digit_editor;

  localparam int BD = 4;

  logic clk = 1'b0;
  logic reset_n, inc, dec, nxt, prv, clr;

  logic [39:0] mem0;
  logic [3:0]  addr0, cur0;
  logic        chg0;
  logic [5:0]  e0;
  logic [23:0] d0;

  logic [3:0]  mem1;
  logic [0:0]  addr1;
  logic [3:0]  cur1;
  logic        chg1;
  logic [5:0]  e1;
  logic [23:0] d1;

  digit_editor #(.DIGITS(10), .RADIX(10), .BLINK_DIV(BD)) u_dut (
    .clk(clk), .reset_n(reset_n), .inc(inc), .dec(dec), .nxt(nxt), .prv(prv), .clr(clr),
    .mem(mem0), .addr(addr0), .cur(cur0), .changed(chg0), .e(e0), .d(d0)
  );

  digit_editor #(.DIGITS(1), .RADIX(16), .BLINK_DIV(BD)) u_hex (
    .clk(clk), .reset_n(reset_n), .inc(inc), .dec(dec), .nxt(nxt), .prv(prv), .clr(clr),
    .mem(mem1), .addr(addr1), .cur(cur1), .changed(chg1), .e(e1), .d(d1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer digits and cursor per instance
  int ndig [2] = '{10, 1};
  int rad  [2] = '{10, 16};
  int m_dig [2][10];
  int m_addr [2];
  bit m_chg [2];
  bit m_phase = 1'b1;
  int m_cnt = 0;

  // pulse vector bit order: {clr, inc, dec, nxt, prv}
  task automatic model_edge(input logic rn, input logic [4:0] p);
    for (int k = 0; k < 2; k++) begin
      m_chg[k] = 1'b0;
      if (!rn) begin
        for (int i = 0; i < 10; i++) m_dig[k][i] = 0;
        m_addr[k] = 0;
      end else if (p[4]) begin
        for (int i = 0; i < 10; i++) m_dig[k][i] = 0;
        m_chg[k] = 1'b1;
      end else if (p[3]) begin
        m_dig[k][m_addr[k]] = (m_dig[k][m_addr[k]] + 1) % rad[k];
        m_chg[k] = 1'b1;
      end else if (p[2]) begin
        m_dig[k][m_addr[k]] = (m_dig[k][m_addr[k]] + rad[k] - 1) % rad[k];
        m_chg[k] = 1'b1;
      end else if (p[1]) begin
        m_addr[k] = (m_addr[k] + 1) % ndig[k];
      end else if (p[0]) begin
        m_addr[k] = (m_addr[k] + ndig[k] - 1) % ndig[k];
      end
    end
    if (!rn || p != 5'b0) begin
      m_cnt   = 0;
      m_phase = 1'b1;
    end else begin
      m_cnt++;
      if (m_cnt == BD) begin
        m_cnt   = 0;
        m_phase = !m_phase;
      end
    end
  endtask

  function automatic logic [5:0] exp_e();
`ifdef DIGIT_EDITOR_BLINK_EN
    return {5'b11000, m_phase};
`else
    return 6'b11_0001;
`endif
  endfunction

  function automatic logic [23:0] exp_d(input int k);
    logic [23:0] r;
    r = '0;
    r[23:20] = 4'((m_addr[k] + 1) / 10);
    r[19:16] = 4'((m_addr[k] + 1) % 10);
    r[3:0]   = 4'(m_dig[k][m_addr[k]]);
    return r;
  endfunction

  task automatic compare_all();
    logic [63:0] em0, em1;
    em0 = '0;
    em1 = '0;
    for (int i = 0; i < 10; i++) em0[4*i +: 4] = 4'(m_dig[0][i]);
    em1[3:0] = 4'(m_dig[1][0]);
    check("mem0",  64'(mem0),  em0);
    check("addr0", 64'(addr0), 64'(m_addr[0]));
    check("cur0",  64'(cur0),  64'(m_dig[0][m_addr[0]]));
    check("chg0",  64'(chg0),  64'(m_chg[0]));
    check("d0",    64'(d0),    64'(exp_d(0)));
    check("e0",    64'(e0),    64'(exp_e()));
    check("mem1",  64'(mem1),  em1);
    check("addr1", 64'(addr1), 64'(m_addr[1]));
    check("cur1",  64'(cur1),  64'(m_dig[1][0]));
    check("chg1",  64'(chg1),  64'(m_chg[1]));
    check("d1",    64'(d1),    64'(exp_d(1)));
    check("e1",    64'(e1),    64'(exp_e()));
  endtask

  task automatic step(input logic rn, input logic [4:0] p);
    reset_n = rn;
    {clr, inc, dec, nxt, prv} = p;
    @(posedge clk);
    model_edge(rn, p);
    #1;
    compare_all();
  endtask

  localparam logic [4:0] P_CLR = 5'b10000, P_INC = 5'b01000, P_DEC = 5'b00100,
                         P_NXT = 5'b00010, P_PRV = 5'b00001, P_IDLE = 5'b00000;

  initial begin
    int hits;
    logic [4:0] p;
    logic rn;

    step(1'b0, P_IDLE);
    step(1'b0, P_IDLE);

    hits = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, P_NXT);
      if (chg0) hits++;
    end
    check("nxt12_addr", 64'(addr0), 64'd2);
    check("nxt12_hex", 64'(d0[23:16]), 64'h03);
    check("nxt12_mem", 64'(mem0), 64'd0);
    check("nxt12_chg_count", 64'(hits), 64'd0);

    step(1'b1, P_NXT);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, P_INC);
      if (chg0) hits++;
    end
    check("inc10_digit3", 64'(mem0[15:12]), 64'd0);
    check("inc10_chg_count", 64'(hits), 64'd10);
    check("hex_inc10", 64'(mem1), 64'hA);

    for (int i = 0; i < 3; i++) step(1'b1, P_PRV);
    step(1'b1, P_CLR);
    step(1'b1, P_DEC);
    check("dec_wrap_r10", 64'(mem0[3:0]), 64'd9);
    check("dec_wrap_r16", 64'(mem1), 64'hF);
    step(1'b1, P_PRV);
    check("prv_wrap_addr", 64'(addr0), 64'd9);
    check("prv_wrap_hex", 64'(d0[23:16]), 64'h10);

    for (int i = 0; i < 5; i++) step(1'b1, P_INC);
    step(1'b1, P_INC | P_DEC | P_NXT);
    check("prio_digit", 64'(mem0[39:36]), 64'd6);
    check("prio_addr", 64'(addr0), 64'd9);
    step(1'b1, P_CLR | P_INC);
    check("clr_inc_mem", 64'(mem0), 64'd0);
    check("clr_inc_chg", 64'(chg0), 64'd1);
    step(1'b1, P_CLR);
    check("clr_zero_chg", 64'(chg0), 64'd1);

    step(1'b1, P_INC);
    step(1'b1, P_INC);
    step(1'b0, P_INC);
    check("rst_mem", 64'(mem0), 64'd0);
    check("rst_addr", 64'(addr0), 64'd0);
    check("rst_chg", 64'(chg0), 64'd0);

    step(1'b1, P_NXT);
    check("blink_restart", 64'(e0[0]), 64'd1);
    for (int i = 0; i < 12; i++) step(1'b1, P_IDLE);

    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(0, 63) != 0);
      for (int b = 0; b < 5; b++) p[b] = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) p = P_IDLE;
      step(rn, p);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
